// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU arbiter: opcode encodings, datapath width
// and the in-flight tag carried alongside each FPU operation.
package fpu_pkg;

    localparam int FPU_W = 32;

    localparam logic [1:0] FPU_OP_ADD = 2'b00;
    localparam logic [1:0] FPU_OP_SUB = 2'b01;
    localparam logic [1:0] FPU_OP_MUL = 2'b10;
    localparam logic [1:0] FPU_OP_DIV = 2'b11;

    // Wide enough for the largest supported requester count (8).
    localparam int TAG_IDW = 3;

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } fpu_tag_t;

endpackage

// File: rtl/fpu_arbiter_rr_pick.sv
// Combinational round-robin picker: searches from last+1 (mod NREQ) and
// returns a one-hot grant plus its index.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            en,
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            any
);

    // First valid requester after the last winner takes the grant.
    always_comb begin
        int idx;
        idx      = 0;
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (en && valid[idx] && !any) begin
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
                any        = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin front end for a shared fixed-latency FPU; results are routed
// back by a tag pipe. Define FPU_ARB_STATS_EN to add per-requester grant counters.
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int FPU_LAT = 4,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arb_en,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*FPU_W-1:0] req_a,
    input  logic [NREQ*FPU_W-1:0] req_b,
    input  logic [NREQ*2-1:0]     req_op,
    output logic [FPU_W-1:0]      fpu_a,
    output logic [FPU_W-1:0]      fpu_b,
    output logic [1:0]            fpu_op,
    output logic                  fpu_issue,
    input  logic [FPU_W-1:0]      fpu_outp,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [FPU_W-1:0]      rsp_data,
    output logic                  busy
`ifdef FPU_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]    stat_grants
`endif
);

    logic [NREQ-1:0]  grant_s;
    logic [IDW-1:0]   grant_id_s;
    logic             accept_s;

    logic [IDW-1:0]   last_q, last_d;
    logic [FPU_W-1:0] fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
    logic [1:0]       fpu_op_q, fpu_op_d;
    logic             fpu_issue_q, fpu_issue_d;
    fpu_tag_t         tag_q [FPU_LAT+1];
    fpu_tag_t         tag_d [FPU_LAT+1];
    fpu_tag_t         exit_s;
    logic             exit_ok_s;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [FPU_W-1:0] rsp_data_q, rsp_data_d;
    logic             busy_q, busy_d;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .en       (arb_en),
        .valid    (req_valid),
        .last     (last_q),
        .grant    (grant_s),
        .grant_id (grant_id_s),
        .any      (accept_s)
    );

    assign req_ready = grant_s;

    // Operand capture and round-robin pointer update on accept.
    always_comb begin
        fpu_a_d     = fpu_a_q;
        fpu_b_d     = fpu_b_q;
        fpu_op_d    = fpu_op_q;
        last_d      = last_q;
        fpu_issue_d = 1'b0;
        if (accept_s) begin
            fpu_a_d     = req_a[FPU_W*int'(grant_id_s) +: FPU_W];
            fpu_b_d     = req_b[FPU_W*int'(grant_id_s) +: FPU_W];
            fpu_op_d    = req_op[2*int'(grant_id_s) +: 2];
            last_d      = grant_id_s;
            fpu_issue_d = 1'b1;
        end else begin
            fpu_issue_d = 1'b0;
        end
    end

    // Tag pipe shift; a bubble enters whenever nothing is accepted.
    always_comb begin
        tag_d[0].valid = accept_s;
        tag_d[0].id    = TAG_IDW'(grant_id_s);
        for (int k = 1; k <= FPU_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
        busy_d = 1'b0;
        for (int k = 0; k <= FPU_LAT; k++) begin
            busy_d = busy_d | tag_d[k].valid;
        end
    end

    // Out-of-range IDs are treated as corrupt tags and never produce a response.
    assign exit_s    = tag_q[FPU_LAT];
    assign exit_ok_s = exit_s.valid && (int'(exit_s.id) < NREQ);

    // Response capture when a live tag leaves the pipe.
    always_comb begin
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        if (exit_ok_s) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = exit_s.id[IDW-1:0];
            rsp_data_d  = fpu_outp;
        end else begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= IDW'(NREQ - 1);
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            fpu_op_q    <= 2'b00;
            fpu_issue_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            for (int k = 0; k <= FPU_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            last_q      <= last_d;
            fpu_a_q     <= fpu_a_d;
            fpu_b_q     <= fpu_b_d;
            fpu_op_q    <= fpu_op_d;
            fpu_issue_q <= fpu_issue_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            for (int k = 0; k <= FPU_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign fpu_a     = fpu_a_q;
    assign fpu_b     = fpu_b_q;
    assign fpu_op    = fpu_op_q;
    assign fpu_issue = fpu_issue_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

`ifdef FPU_ARB_STATS_EN
    logic [15:0] stat_q [NREQ];
    logic [15:0] stat_d [NREQ];

    // Saturating per-requester accept counters.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            if (grant_s[i] && (stat_q[i] != 16'hFFFF)) begin
                stat_d[i] = stat_q[i] + 16'd1;
            end else begin
                stat_d[i] = stat_q[i];
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                stat_q[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            stat_grants[16*i +: 16] = stat_q[i];
        end
    end
`endif

endmodule
